// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcodes, ALU op codes
// and the decoded-instruction record latched at the start of execute.
package ctrl_pkg;

  typedef enum logic [3:0] {
    RST = 4'd0,
    T0  = 4'd1,
    T1  = 4'd2,
    T2  = 4'd3,
    T3  = 4'd4,
    T4  = 4'd5,
    T5  = 4'd6,
    T6  = 4'd7,
    HLT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_DIV  = 4'd6;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_muldiv;
    logic       is_halt;
    logic       is_nop;
  } decode_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode classifier; zero latency, no flow control.
// NOP and every undefined opcode both report is_nop.
module op_decoder
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] alu_op,
  output logic       is_muldiv,
  output logic       is_halt,
  output logic       is_nop
);

  always_comb begin
    alu_op    = ALU_NONE;
    is_muldiv = 1'b0;
    is_halt   = 1'b0;
    is_nop    = 1'b0;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_MUL: begin
        alu_op    = ALU_MUL;
        is_muldiv = 1'b1;
      end
      OP_DIV: begin
        alu_op    = ALU_DIV;
        is_muldiv = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM: fetch T0-T2 (T1 stretches on mem_ready), execute T3-T6, halt on stop/HALT.
// ALU op 6 cycles, mul/div 7, nop 4, +1 per memory wait; stop is honoured only at T0 entry.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int IR_W  = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [IR_W-1:0]  ir,
  input  logic             mem_ready,
  input  logic             stop,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [3:0]       alu_op,
  output logic             run,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state, state_nxt;
  decode_t          dec, op_q;
  logic             t1_wait;
  logic             instr_done;
  logic [CNT_W-1:0] cnt;

  logic [3:0] dec_alu_op;
  logic       dec_muldiv, dec_halt, dec_nop;

  // Register fields are routed by the datapath itself through Gra/Grb/Grc.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[IR_W-6:0];

  op_decoder u_op_decoder (
    .opcode    (ir[IR_W-1 -: 5]),
    .alu_op    (dec_alu_op),
    .is_muldiv (dec_muldiv),
    .is_halt   (dec_halt),
    .is_nop    (dec_nop)
  );

  assign dec = {dec_alu_op, dec_muldiv, dec_halt, dec_nop};

  always_comb begin
    state_nxt  = state;
    instr_done = 1'b0;
    case (state)
      RST: state_nxt = T0;
      T0:  state_nxt = T1;
      T1:  if (mem_ready) state_nxt = T2;
      T2:  state_nxt = T3;
      T3: begin
        if (op_q.is_halt)     state_nxt = HLT;
        else if (op_q.is_nop) instr_done = 1'b1;
        else                  state_nxt = T4;
      end
      T4:  state_nxt = T5;
      T5: begin
        if (op_q.is_muldiv) state_nxt = T6;
        else                instr_done = 1'b1;
      end
      T6:  instr_done = 1'b1;
      HLT: state_nxt = HLT;
      default: state_nxt = RST;
    endcase
    // Every completed instruction lands on the boundary where stop is sampled.
    if (instr_done) state_nxt = stop ? HLT : T0;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= RST;
      op_q    <= '0;
      t1_wait <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      t1_wait <= (state == T1);
      if (state == T2) op_q <= dec;
      if (instr_done)  cnt  <= cnt + CNT_W'(1);
    end
  end

  assign instr_count = cnt;

  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = ALU_NONE;
    run      = 1'b1;
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = !t1_wait;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (!op_q.is_nop && !op_q.is_halt) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      T4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = op_q.alu_op;
      end
      T5: begin
        Zlowout = 1'b1;
        if (op_q.is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      HLT: run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: expected per-cycle strobe vectors are built from the
// instruction class table and walked in lockstep with the design.
module tb_control_sequencer;

  localparam int CW = 4;

  logic          clock;
  logic          clear;
  logic [31:0]   ir;
  logic          mem_ready;
  logic          stop;
  logic          PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic          Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic          Gra, Grb, Grc, Rin, Rout;
  logic [3:0]    alu_op;
  logic          run;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int cnt = 0;

  localparam int PCOUT = 18, PCIN = 17, INCPC = 16, MARIN = 15, READ = 14, MDRIN = 13;
  localparam int MDROUT = 12, IRIN = 11, YIN = 10, ZIN = 9, ZLOW = 8, ZHIGH = 7;
  localparam int HIIN = 6, LOIN = 5, GRA = 4, GRB = 3, GRC = 2, RIN = 1, ROUT = 0;

  logic [23:0] obs;
  assign obs = {run, alu_op, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                Yin, Zin, Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout};

  control_sequencer #(.CNT_W(CW), .IR_W(32)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .run(run), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [18:0] b(input int i);
    return 19'(1) << i;
  endfunction

  function automatic logic [23:0] vec(input logic [18:0] s, input logic [3:0] op, input logic r);
    return {r, op, s};
  endfunction

  // kind: 0 = nop/undefined, 1 = ALU, 2 = mul/div, 3 = halt
  function automatic void classify(input logic [4:0] opc, output int kind, output logic [3:0] aop);
    kind = 0;
    aop  = 4'd0;
    case (opc)
      5'b00011: begin kind = 1; aop = 4'd1; end
      5'b00100: begin kind = 1; aop = 4'd2; end
      5'b00101: begin kind = 1; aop = 4'd3; end
      5'b00110: begin kind = 1; aop = 4'd4; end
      5'b01110: begin kind = 2; aop = 4'd5; end
      5'b01111: begin kind = 2; aop = 4'd6; end
      5'b11011: kind = 3;
      default:  kind = 0;
    endcase
  endfunction

  // Entered just after a clock edge with the design in T0; leaves it just after the
  // edge that ends the instruction (design then in T0 or HLT).
  task automatic run_instr(input logic [31:0] word, input int waits, input logic stop_final,
                           output logic halted);
    logic [23:0] exp_q[$];
    logic        mr_q[$];
    int          kind;
    logic [3:0]  aop;
    int          t3_idx;
    int          last;
    classify(word[31:27], kind, aop);
    exp_q.push_back(vec(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), 4'd0, 1'b1));
    mr_q.push_back(1'($urandom_range(0, 1)));
    for (int w = 0; w <= waits; w++) begin
      exp_q.push_back(vec((w == 0 ? b(PCIN) : 19'd0) | b(ZLOW) | b(READ) | b(MDRIN), 4'd0, 1'b1));
      mr_q.push_back(w == waits);
    end
    exp_q.push_back(vec(b(MDROUT) | b(IRIN), 4'd0, 1'b1));
    mr_q.push_back(1'($urandom_range(0, 1)));
    t3_idx = exp_q.size();
    if (kind == 0 || kind == 3) exp_q.push_back(vec(19'd0, 4'd0, 1'b1));
    else                        exp_q.push_back(vec(b(GRB) | b(ROUT) | b(YIN), 4'd0, 1'b1));
    mr_q.push_back(1'($urandom_range(0, 1)));
    if (kind == 1 || kind == 2) begin
      exp_q.push_back(vec(b(GRC) | b(ROUT) | b(ZIN), aop, 1'b1));
      mr_q.push_back(1'($urandom_range(0, 1)));
    end
    if (kind == 1) begin
      exp_q.push_back(vec(b(ZLOW) | b(GRA) | b(RIN), 4'd0, 1'b1));
      mr_q.push_back(1'($urandom_range(0, 1)));
    end
    if (kind == 2) begin
      exp_q.push_back(vec(b(ZLOW) | b(LOIN), 4'd0, 1'b1));
      exp_q.push_back(vec(b(ZHIGH) | b(HIIN), 4'd0, 1'b1));
      mr_q.push_back(1'($urandom_range(0, 1)));
      mr_q.push_back(1'($urandom_range(0, 1)));
    end
    last = exp_q.size() - 1;
    ir = word;
    for (int k = 0; k <= last; k++) begin
      checks++;
      if (obs !== exp_q[k]) begin
        errors++;
        $display("FAIL strobes ir=%h cycle %0d: got %h expected %h", word, k, obs, exp_q[k]);
      end
      checks++;
      if (instr_count !== CW'(cnt)) begin
        errors++;
        $display("FAIL instr_count ir=%h cycle %0d: got %0d expected %0d", word, k, instr_count, cnt);
      end
      mem_ready = mr_q[k];
      stop = (k == last) ? stop_final : 1'($urandom_range(0, 1));
      if (k == t3_idx) ir = $urandom();
      @(posedge clock);
      #1;
    end
    if (kind != 3) cnt = (cnt + 1) % (1 << CW);
    halted = (kind == 3) || stop_final;
  endtask

  task automatic do_clear;
    @(negedge clock);
    clear = 1'b1;
    stop = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    cnt = 0;
  endtask

  task automatic test_reset;
    clear = 1'b0;
    stop = 1'b0;
    mem_ready = 1'b0;
    ir = 32'h0;
    #2 clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs !== vec(19'd0, 4'd0, 1'b1)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, vec(19'd0, 4'd0, 1'b1));
    end
    checks++;
    if (instr_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
    @(negedge clock);
    clear = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== vec(19'd0, 4'd0, 1'b1)) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, vec(19'd0, 4'd0, 1'b1));
    end
    @(posedge clock);
    #1;
    checks++;
    if (obs !== vec(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), 4'd0, 1'b1)) begin
      errors++;
      $display("FAIL reset_to_t0: got %h", obs);
    end
    cnt = 0;
  endtask

  task automatic test_alu_fetch;
    logic h;
    run_instr(32'h30918000, 0, 1'b0, h);
    checks++;
    if (instr_count !== CW'(1)) begin
      errors++;
      $display("FAIL alu_count: got %0d expected 1", instr_count);
    end
  endtask

  task automatic test_mem_wait;
    logic h;
    run_instr(32'h18000000, 3, 1'b0, h);
    checks++;
    if (instr_count !== CW'(2)) begin
      errors++;
      $display("FAIL mem_wait_count: got %0d expected 2", instr_count);
    end
  endtask

  task automatic test_mul;
    logic h;
    int c0;
    c0 = cnt;
    run_instr(32'h70228000, $urandom_range(0, 2), 1'b0, h);
    checks++;
    if (instr_count !== CW'((c0 + 1) % (1 << CW)) || PCout !== 1'b1) begin
      errors++;
      $display("FAIL mul_done: count %0d PCout %b expected count %0d PCout 1", instr_count, PCout, (c0 + 1) % (1 << CW));
    end
  endtask

  task automatic test_halt;
    logic h;
    int c0;
    c0 = cnt;
    run_instr(32'hD8000000, $urandom_range(0, 2), 1'b0, h);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs !== 24'h0 || instr_count !== CW'(c0)) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: outputs %h count %0d expected 000000 count %0d", i, obs, instr_count, c0);
      end
      mem_ready = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    clear = 1'b1;
    stop = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== vec(19'd0, 4'd0, 1'b1) || instr_count !== '0) begin
      errors++;
      $display("FAIL halt_clear: outputs %h count %0d expected %h count 0", obs, instr_count, vec(19'd0, 4'd0, 1'b1));
    end
    clear = 1'b0;
    @(posedge clock);
    #1;
    cnt = 0;
  endtask

  task automatic test_stop;
    logic h;
    int c0;
    c0 = cnt;
    run_instr(32'h20000000, $urandom_range(0, 3), 1'b1, h);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== 24'h0 || instr_count !== CW'((c0 + 1) % (1 << CW))) begin
        errors++;
        $display("FAIL stop_halt cycle %0d: outputs %h count %0d expected 000000 count %0d", i, obs, instr_count, (c0 + 1) % (1 << CW));
      end
      stop = 1'b0;
      @(posedge clock);
      #1;
    end
    do_clear();
  endtask

  task automatic test_clear_mid_op;
    logic h;
    run_instr(32'h80000000, 0, 1'b0, h);
    ir = 32'h18000000;
    mem_ready = 1'b1;
    stop = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (obs !== vec(b(GRC) | b(ROUT) | b(ZIN), 4'd1, 1'b1)) begin
      errors++;
      $display("FAIL mid_t4: got %h expected %h", obs, vec(b(GRC) | b(ROUT) | b(ZIN), 4'd1, 1'b1));
    end
    clear = 1'b1;
    #1;
    checks++;
    if (obs !== vec(19'd0, 4'd0, 1'b1) || instr_count !== '0) begin
      errors++;
      $display("FAIL mid_clear: outputs %h count %0d expected %h count 0", obs, instr_count, vec(19'd0, 4'd0, 1'b1));
    end
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    cnt = 0;
    run_instr(32'h18000000, 0, 1'b0, h);
    checks++;
    if (instr_count !== CW'(1)) begin
      errors++;
      $display("FAIL mid_recount: got %0d expected 1", instr_count);
    end
  endtask

  task automatic test_wrap;
    logic h;
    do_clear();
    for (int i = 0; i < (1 << CW) + 1; i++) run_instr(32'h80000000, $urandom_range(0, 1), 1'b0, h);
    checks++;
    if (instr_count !== CW'(1)) begin
      errors++;
      $display("FAIL count_wrap: got %0d expected 1", instr_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] tbl [7];
    logic [31:0] word;
    logic h;
    int r;
    tbl = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01110, 5'b01111, 5'b10000};
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) word = {tbl[r], 27'($urandom)};
      else       word = $urandom();
      run_instr(word, $urandom_range(0, 3), ($urandom_range(0, 29) == 0), h);
      if (h) begin
        checks++;
        if (obs !== 24'h0) begin
          errors++;
          $display("FAIL random_halt: got %h expected 000000", obs);
        end
        do_clear();
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_fetch();
    test_mem_wait();
    test_mul();
    test_halt();
    test_stop();
    test_clear_mid_op();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
